// File: rtl/gray_mem_arb.sv
// Two-requester round-robin arbiter in front of the gray-pixel read memory.
// Grants are held for a burst of up to BURST_MAX beats; read data returns one cycle after accept.
module gray_mem_arb #(
    parameter int unsigned BURST_MAX = 9,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m0_data,
    output logic [DATA_W-1:0] m1_data,
    output logic              m0_dvalid,
    output logic              m1_dvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    state_t     state, state_nxt;
    logic [3:0] burst_cnt;
    logic       last_m1;
    logic       pend_valid;
    logic       pend_m1;
    logic       owner_req;
    logic       accept;
    logic       burst_done;
    logic       release_grant;
    logic       grant_entry;

    assign owner_req     = (state == OWN0) ? m0_req : ((state == OWN1) ? m1_req : 1'b0);
    assign accept        = owner_req & mem_ready;
    assign burst_done    = accept && (burst_cnt == BURST_LAST);
    assign release_grant = (state == IDLE) || !owner_req || burst_done;
    assign grant_entry   = release_grant && (state_nxt != IDLE);

    // NOTE: every register here, including the pending-return flag, is cleared by the
    // asynchronous reset so an in-flight read can never surface as a dvalid afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin: the requester that was not served last gets first pick.
    always_comb begin
        state_nxt = state;
        if (release_grant) begin
            if (last_m1 ? m0_req : m1_req) begin
                state_nxt = last_m1 ? OWN0 : OWN1;
            end else if (last_m1 ? m1_req : m0_req) begin
                state_nxt = last_m1 ? OWN1 : OWN0;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        unique case (state)
            OWN0: begin
                m0_gnt   = 1'b1;
                mem_req  = m0_req;
                mem_addr = m0_addr;
            end
            OWN1: begin
                m1_gnt   = 1'b1;
                mem_req  = m1_req;
                mem_addr = m1_addr;
            end
            default: begin
                m0_gnt = 1'b0;
            end
        endcase
    end

    // Counter restarts on every grant entry, including an immediate re-grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
            last_m1   <= 1'b1;
        end else if (grant_entry) begin
            burst_cnt <= '0;
            last_m1   <= (state_nxt == OWN1);
        end else if (accept) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

    // Return owner is captured at accept, independent of any grant change on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_m1    <= 1'b0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_m1 <= (state == OWN1);
            end
        end
    end

    assign m0_dvalid = pend_valid & ~pend_m1;
    assign m1_dvalid = pend_valid & pend_m1;
    assign m0_data   = mem_data;
    assign m1_data   = mem_data;
    assign busy      = (state != IDLE) || pend_valid;

endmodule

// File: doc/gray_mem_arb.md
GRAY_MEM_ARB -- requirements
Module: gray_mem_arb

Interface
REQ-001 Parameter: BURST_MAX, default 9, maximum beats per grant before forced re-arbitration (one LBP 3x3 neighbourhood); legal range 1-15.
REQ-002 Parameter: ADDR_W, default 14, gray-memory address width (128x128 image).
REQ-003 Parameter: DATA_W, default 8, gray-pixel width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m0_req / m1_req  input  1  requester n wants a memory beat this cycle (m0 = LBP engine, m1 = secondary image engine).
REQ-007 m0_addr / m1_addr  input  ADDR_W  requester n read address.
REQ-008 m0_gnt / m1_gnt  output  1  requester n currently owns the memory.
REQ-009 m0_data / m1_data  output  DATA_W  read data returned to requester n.
REQ-010 m0_dvalid / m1_dvalid  output  1  one-cycle pulse: mn_data holds valid data.
REQ-011 mem_req  output  1  read request to gray memory.
REQ-012 mem_addr  output  ADDR_W  read address to gray memory.
REQ-013 mem_ready  input  1  memory accepts a request this cycle.
REQ-014 mem_data  input  DATA_W  memory read data, valid in the cycle after an accepted request.
REQ-015 busy  output  1  high while any grant is held or a read is pending.

Function
REQ-016 The FSM SHALL have states IDLE, OWN0, OWN1; mn_gnt SHALL be a decode of state (OWN0 -> m0_gnt, OWN1 -> m1_gnt); both grants SHALL never be high together.
REQ-017 mem_req SHALL equal granted requester's mn_req; mem_addr SHALL equal granted requester's mn_addr (combinational mux); in IDLE mem_req = 0, mem_addr = 0.
REQ-018 A beat SHALL be accepted when mem_req = 1 and mem_ready = 1; a stalled beat (mem_ready = 0) SHALL hold grant and not count.
REQ-019 For each accepted beat the owner's mn_dvalid SHALL pulse exactly one cycle later; mn_data SHALL carry mem_data in that cycle; the non-owner's dvalid SHALL stay 0. Both mn_data outputs SHALL be driven from mem_data.
REQ-020 The pending-return owner SHALL be registered at accept, so dvalid routes correctly even if grant changes in the return cycle.
REQ-021 A 4-bit burst counter SHALL clear on each grant entry and increment per accepted beat.
REQ-022 Release: owner SHALL lose grant at the next edge when (a) counter reaches BURST_MAX on an accepted beat, or (b) owner's mn_req = 0.
REQ-023 Re-arbitration at release or in IDLE SHALL be round-robin: the requester not last served wins if requesting; otherwise the other requester; neither requesting -> IDLE.
REQ-024 Release and new grant SHALL occur on the same edge (zero idle cycles); the same requester SHALL be re-granted immediately if the other is not requesting.
REQ-025 Last-served pointer SHALL update on each grant entry.
REQ-026 From IDLE, a request SHALL be granted at the next edge (one-cycle grant latency); the address issues in the grant cycle.
REQ-027 busy SHALL be high in OWN0/OWN1 or while a dvalid is pending.

Reset
REQ-028 Asserting reset (low) at any time SHALL asynchronously force: state IDLE, both gnt = 0, both dvalid = 0, mem_req = 0, mem_addr = 0, busy = 0, burst counter = 0, last-served pointer = m1 (so m0 wins the first simultaneous request); a pending return SHALL be discarded.
REQ-029 After reset release, the first grant SHALL follow REQ-026.

Verification
REQ-030 Reset, then m0_req held, m1_req = 0, mem_ready = 1 -> m0_gnt high at cycle 1; 9 dvalids on cycles 2-10; m0 re-granted without gap, counter restarts.
REQ-031 m0_req and m1_req rise together from IDLE -> m0 granted first, 9 beats, then m1 granted on the same edge m0 releases, 9 beats, then m0 again.
REQ-032 m1 owns; m0_req rises at m1 beat 4 -> m1 keeps grant through beat 9, m0 granted next edge; m0_dvalid never pulses for m1 beats.
REQ-033 mem_ready = 0 for 3 cycles mid-burst -> grant held, counter frozen, no dvalid in stall cycles, mem_addr stable; burst completes with exactly 9 dvalids.
REQ-034 Owner drops req after 5 beats while other requests -> grant switches next edge; 5th beat's dvalid still routed to original owner.
REQ-035 Reset asserted mid-burst with a return pending -> all outputs 0 immediately, no dvalid after reset release until new accepted beat.
